tone_gen: RTL and testbench
===========================

TONE_GEN -- requirements
Module: tone_gen

Interface
REQ-001 Parameter: CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter: SILENCE_HZ, default 20000, tone values at or above this are silence.
REQ-003 Port: clk  input  1  system clock; all logic is on the rising edge.
REQ-004 Port: rst  input  1  reset; synchronous and active-high.
REQ-005 Port: tone  input  32  requested note frequency in Hz, from the beat-to-tone lookup stage; may change on any cycle.
REQ-006 Port: vol  input  3  volume level; 0 is mute, 7 is loudest.
REQ-007 Port: audio  output  1  PWM square wave to the buzzer/amplifier pin.
REQ-008 Port: tone_active  output  1  high while a valid period is being generated.
REQ-009 Port: busy  output  1  high while a period calculation is in progress.
REQ-010 Port: wrap  output  1  one-cycle pulse on the last clock of each generated period.

Function
REQ-011 Period is P = floor(CLK_FREQ / tone) clocks, computed by a sequential divider with exactly 32 cycles of latency from start to done.
REQ-012 tone is registered every cycle into tone_q. A change is detected when tone differs from tone_q.
REQ-013 Silent condition: tone_q == 0 or tone_q >= SILENCE_HZ.
REQ-014 FSM states are IDLE, CALC and RUN.
REQ-015 IDLE: audio=0, tone_active=0, busy=0. On a change to a non-silent value, go to CALC.
REQ-016 CALC: busy=1. The divider is started on entry. Audio keeps the old period if CALC was entered from RUN; otherwise audio=0.
REQ-017 CALC, tone changes again before done: abort and restart the divider with the newest tone. Restart latency is again 32 cycles.
REQ-018 CALC, done: the result goes to a pending register, then the FSM goes to RUN. If the previous state was IDLE, the new period is loaded immediately and the counter starts at 0. If the previous state was RUN, the new period is loaded at the next wrap of the old period, so no truncated or glitched cycle is produced.
REQ-019 RUN: tone_active=1. A period counter counts 0..P-1.
REQ-020 RUN: wrap=1 when the counter equals P-1; the counter returns to 0 on the next cycle.
REQ-021 RUN, tone changes to a non-silent value: go to CALC while the current period continues.
REQ-022 Duty cycle: audio=1 while counter < H, where H = (P >> 1) >> (7 - vol).
- vol=7 gives 50% duty; vol=6 gives 25%; each lower step halves it again.
- vol=0 forces audio=0 while the counter and wrap keep running.
REQ-023 vol is sampled only at wrap. A vol change takes effect in the next period.
REQ-024 Any transition to the silent condition, from CALC or RUN, goes to IDLE on the next cycle. On that cycle audio=0 and tone_active=0, and any divider operation is aborted.
REQ-025 All arithmetic is unsigned 32-bit. P=0 cannot occur for legal CLK_FREQ and non-silent tone. A pending P of 1 is treated as 2.

Reset
REQ-026 While rst=1, and on the cycle after it:
- state=IDLE, tone_q=0, counter=0, P=0, pending=0, H=0
- audio=0, tone_active=0, busy=0, wrap=0
REQ-027 rst asserted mid-CALC or mid-RUN aborts immediately, with no partial output.
REQ-028 After rst deasserts, a steady non-silent tone is treated as a change (tone_q=0) and triggers CALC.

Structure
REQ-029 Shared package tone_pkg holds:
- the FSM state enum
- the NO_SING constant 20000
- the default CLK_FREQ constant
REQ-030 One sub-module, seq_div, implements the 32-bit restoring divider.
- Ports: clk, rst, start, abort, dividend, divisor, quotient, done.
- start, abort and done are one-cycle pulses.

Verification
REQ-031 Bench runs with CLK_FREQ=1_000_000.
REQ-032 Reset, then tone=1046, vol=7 → busy high for 32 cycles, then audio period 956 clocks, high for 478 clocks, wrap every 956 clocks.
REQ-033 In RUN at 1046, switch to tone=880 mid-period → old period completes intact, then the period is 1136 with high time 568, and there are no short pulses.
REQ-034 tone=1046, vol changes 7→5 mid-period → current period keeps high time 478, the next period has high time 119.
REQ-035 In RUN, tone=20000 → next cycle audio=0, tone_active=0, state IDLE. Then tone=0 → stays IDLE.
REQ-036 tone changes 659→783 at cycle 10 of CALC → busy stays high until 32 cycles after the restart, and the final period is 1277.
REQ-037 rst pulsed mid-RUN → all outputs 0 on the next cycle. With tone held at 988 after reset, RUN resumes with period 1012.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared types and constants for the tone generator: FSM states, silence
// threshold, default clock and the volume-to-high-time helper.
package tone_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam int unsigned NO_SING      = 20000;
    localparam int unsigned DEF_CLK_FREQ = 100_000_000;

    // High time of one period: half the period, halved again per step below full volume.
    function automatic logic [31:0] duty_high(input logic [31:0] per, input logic [2:0] vol);
        if (vol == 3'd0) begin
            return 32'd0;
        end
        return (per >> 1) >> (3'd7 - vol);
    endfunction

endpackage

// File: rtl/seq_div.sv
// 32-bit restoring divider: one quotient bit per clock, the first bit is
// resolved on the start edge so done pulses exactly 32 cycles after start.
module seq_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic        done
);

    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [4:0]  cnt_q;
    logic        run_q;
    logic        done_q;

    // Shift one dividend bit into the remainder and subtract if it fits.
    function automatic logic [63:0] div_step(input logic [31:0] rem, input logic [31:0] quo,
                                             input logic [31:0] dvs);
        logic [32:0] r;
        logic [32:0] d;
        r = {rem, quo[31]};
        d = r - {1'b0, dvs};
        if (!d[32]) begin
            return {d[31:0], quo[30:0], 1'b1};
        end
        return {r[31:0], quo[30:0], 1'b0};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q  <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= 5'd0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                run_q <= 1'b0;
            end else if (start) begin
                run_q <= 1'b1;
                cnt_q <= 5'd1;
            end else if (run_q) begin
                cnt_q <= cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start && !abort) begin
            {rem_q, quo_q} <= div_step(32'd0, dividend, divisor);
            dvs_q          <= divisor;
        end else if (run_q) begin
            {rem_q, quo_q} <= div_step(rem_q, quo_q, dvs_q);
        end
    end

    assign quotient = quo_q;
    assign done     = done_q;

endmodule

// File: rtl/tone_gen.sv
// PWM square-wave tone generator: divides the clock by the requested note
// frequency and swaps in new periods only at period boundaries.
module tone_gen
    import tone_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
    parameter int unsigned SILENCE_HZ = NO_SING
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] tone,
    input  logic [2:0]  vol,
    output logic        audio,
    output logic        tone_active,
    output logic        busy,
    output logic        wrap
);

    state_t      state_q, state_d;
    logic [31:0] tone_q;
    logic        gen_q, gen_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] per_q, per_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic        audio_q, audio_d;
    logic        active_q, active_d;
    logic        busy_q, busy_d;
    logic        wrap_q, wrap_d;

    logic        chg, tone_sil, go_idle, go_calc, load_now;
    logic        div_done;
    logic [31:0] div_q, q_fix;

    seq_div u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (go_calc),
        .abort    (go_idle),
        .dividend (CLK_FREQ),
        .divisor  (tone),
        .quotient (div_q),
        .done     (div_done)
    );

    always_comb begin
        chg        = (tone != tone_q);
        tone_sil   = (tone == 32'd0) || (tone >= SILENCE_HZ);
        go_idle    = chg && tone_sil;
        go_calc    = chg && !tone_sil;
        q_fix      = (div_q < 32'd2) ? 32'd2 : div_q;
        state_d    = state_q;
        gen_d      = gen_q;
        cnt_d      = cnt_q;
        per_d      = per_q;
        hi_d       = hi_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        load_now   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (go_calc) state_d = ST_CALC;
            end
            ST_CALC, ST_RUN: begin
                if (go_idle) begin
                    state_d = ST_IDLE;
                end else if (go_calc) begin
                    state_d    = ST_CALC;
                    pend_vld_d = 1'b0;
                end else if (state_q == ST_CALC && div_done) begin
                    state_d = ST_RUN;
                    pend_d  = q_fix;
                    if (gen_q) pend_vld_d = 1'b1;
                    else       load_now   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A running period always completes; a pending period replaces it at the wrap.
        if (state_d == ST_IDLE) begin
            gen_d      = 1'b0;
            cnt_d      = 32'd0;
            per_d      = 32'd0;
            hi_d       = 32'd0;
            pend_vld_d = 1'b0;
        end else if (load_now) begin
            gen_d = 1'b1;
            cnt_d = 32'd0;
            per_d = q_fix;
            hi_d  = duty_high(q_fix, vol);
        end else if (gen_q) begin
            if (cnt_q == per_q - 32'd1) begin
                cnt_d = 32'd0;
                if (pend_vld_d) begin
                    per_d      = pend_d;
                    pend_vld_d = 1'b0;
                end
                hi_d = duty_high(per_d, vol);
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end

        audio_d  = gen_d && (cnt_d < hi_d);
        active_d = gen_d;
        busy_d   = (state_d == ST_CALC);
        wrap_d   = gen_d && (cnt_d == per_d - 32'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tone_q     <= 32'd0;
            gen_q      <= 1'b0;
            cnt_q      <= 32'd0;
            per_q      <= 32'd0;
            hi_q       <= 32'd0;
            pend_q     <= 32'd0;
            pend_vld_q <= 1'b0;
            audio_q    <= 1'b0;
            active_q   <= 1'b0;
            busy_q     <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tone_q     <= tone;
            gen_q      <= gen_d;
            cnt_q      <= cnt_d;
            per_q      <= per_d;
            hi_q       <= hi_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            audio_q    <= audio_d;
            active_q   <= active_d;
            busy_q     <= busy_d;
            wrap_q     <= wrap_d;
        end
    end

    assign audio       = audio_q;
    assign tone_active = active_q;
    assign busy        = busy_q;
    assign wrap        = wrap_q;

endmodule

// File: tb/tb_tone_gen.sv
// Bench for tone_gen: per-cycle scoreboard against a behavioural model,
// plus measured period/high-time/busy-length checks for the named scenarios.
module tb_tone_gen;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int M_IDLE = 0;
    localparam int M_CALC = 1;
    localparam int M_RUN  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] tone;
    logic [2:0]  vol;
    logic        audio, tone_active, busy, wrap;

    tone_gen #(.CLK_FREQ(CLK_HZ), .SILENCE_HZ(20000)) dut (
        .clk         (clk),
        .rst         (rst),
        .tone        (tone),
        .vol         (vol),
        .audio       (audio),
        .tone_active (tone_active),
        .busy        (busy),
        .wrap        (wrap)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic audio; logic active; logic busy; logic wrap; } out_t;
    typedef struct packed { int len; int high; } per_t;

    out_t exp_q[$];
    per_t plog[$];
    int   busy_runs[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mlen = 0, mhigh = 0, brun = 0;

    // Reference model state
    int          m_state = M_IDLE;
    int unsigned m_prev = 0, m_calc_tone = 0, m_left = 0;
    int unsigned m_cnt = 0, m_P = 0, m_H = 0, m_pend = 0;
    bit          m_gen = 0, m_pvld = 0;

    function automatic int unsigned hi_of(input int unsigned p, input int unsigned v);
        if (v == 0) return 0;
        return (p / 2) / (32'd1 << (7 - v));
    endfunction

    task automatic model_step();
        out_t        e;
        bit          chg, sil, load;
        int unsigned q;
        if (rst) begin
            m_state = M_IDLE; m_prev = 0; m_gen = 0; m_cnt = 0;
            m_P = 0; m_H = 0; m_pvld = 0; m_pend = 0;
        end else begin
            chg  = (tone != m_prev);
            sil  = (tone == 0) || (tone >= 20000);
            load = 0;
            if (chg && sil) begin
                m_state = M_IDLE; m_gen = 0; m_cnt = 0; m_P = 0; m_H = 0; m_pvld = 0;
            end else begin
                if (chg) begin
                    m_state = M_CALC; m_left = 32; m_calc_tone = tone; m_pvld = 0;
                end else if (m_state == M_CALC) begin
                    if (m_left == 1) begin
                        q = CLK_HZ / m_calc_tone;
                        if (q < 2) q = 2;
                        m_state = M_RUN;
                        if (m_gen) begin
                            m_pend = q; m_pvld = 1;
                        end else begin
                            m_gen = 1; m_P = q; m_cnt = 0; m_H = hi_of(q, vol); load = 1;
                        end
                    end else begin
                        m_left--;
                    end
                end
                if (m_gen && !load) begin
                    if (m_cnt == m_P - 1) begin
                        m_cnt = 0;
                        if (m_pvld) begin m_P = m_pend; m_pvld = 0; end
                        m_H = hi_of(m_P, vol);
                    end else begin
                        m_cnt++;
                    end
                end
            end
            m_prev = tone;
        end
        e.audio  = m_gen && (m_cnt < m_H);
        e.active = m_gen;
        e.busy   = (m_state == M_CALC);
        e.wrap   = m_gen && (m_cnt == m_P - 1);
        exp_q.push_back(e);
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic int plen(input int i);
        return (i < plog.size()) ? plog[i].len : -1;
    endfunction
    function automatic int phigh(input int i);
        return (i < plog.size()) ? plog[i].high : -1;
    endfunction
    function automatic int brun_at(input int i);
        return (i < busy_runs.size()) ? busy_runs[i] : -1;
    endfunction

    // Monitor: scoreboard compare plus period and busy-run measurement.
    initial begin
        out_t       e;
        logic [3:0] a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {audio, tone_active, busy, wrap};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL outputs @%0t: got audio/active/busy/wrap=%b, required %b",
                             $time, a, e);
                end
            end
            if (!tone_active) begin
                mlen = 0; mhigh = 0;
            end else begin
                mlen++;
                if (audio) mhigh++;
                if (wrap) begin
                    plog.push_back('{len: mlen, high: mhigh});
                    mlen = 0; mhigh = 0;
                end
            end
            if (busy) brun++;
            else if (brun > 0) begin
                busy_runs.push_back(brun);
                brun = 0;
            end
        end
    end

    initial begin
        #50_000_000;
        $display("FAIL watchdog: got no finish, required finish before timeout");
        $fatal(1);
    end

    initial begin
        int k, bad, hold;
        rst = 1'b1; tone = 32'd0; vol = 3'd7;
        repeat (3) tick();
        chk("reset_audio", int'(audio), 0);
        chk("reset_active", int'(tone_active), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_wrap", int'(wrap), 0);
        rst = 1'b0;
        tick();

        // Basic tone at full volume
        plog.delete(); busy_runs.delete();
        tone = 32'd1046;
        repeat (32 + 956 * 2 + 10) tick();
        chk("calc_busy_len", brun_at(0), 32);
        chk("p1046_len0", plen(0), 956);
        chk("p1046_high0", phigh(0), 478);
        chk("p1046_len1", plen(1), 956);
        chk("p1046_high1", phigh(1), 478);

        // Tone switch mid-period: old period completes, no short pulses
        repeat (300) tick();
        plog.delete();
        tone = 32'd880;
        repeat (956 + 1136 * 2 + 50) tick();
        chk("switch_first_len", plen(0), 956);
        chk("switch_first_high", phigh(0), 478);
        chk("switch_last_len", plen(plog.size() - 1), 1136);
        chk("switch_last_high", phigh(plog.size() - 1), 568);
        bad = 0;
        foreach (plog[i])
            if (!((plog[i].len == 956 && plog[i].high == 478) ||
                  (plog[i].len == 1136 && plog[i].high == 568))) bad++;
        chk("switch_glitch_periods", bad, 0);

        // Volume change mid-period takes effect at the next period
        tone = 32'd1046;
        repeat (1300) tick();
        k = 0;
        while (!wrap && k < 3000) begin tick(); k++; end
        chk("vol_wrap_found", int'(k < 3000), 1);
        repeat (400) tick();
        plog.delete();
        vol = 3'd5;
        repeat (956 * 2 + 100) tick();
        chk("vol_cur_high", phigh(0), 478);
        chk("vol_next_len", plen(1), 956);
        chk("vol_next_high", phigh(1), 119);

        // Silence from RUN, then tone 0 stays idle
        vol = 3'd7;
        repeat (300) tick();
        tone = 32'd20000;
        tick();
        chk("sil_audio", int'(audio), 0);
        chk("sil_active", int'(tone_active), 0);
        chk("sil_busy", int'(busy), 0);
        tone = 32'd0;
        repeat (50) tick();
        chk("zero_active", int'(tone_active), 0);
        chk("zero_busy", int'(busy), 0);

        // Restart during CALC
        plog.delete(); busy_runs.delete();
        tone = 32'd659;
        repeat (10) tick();
        tone = 32'd783;
        repeat (32 + 1277 * 2 + 20) tick();
        chk("restart_busy_len", brun_at(0), 42);
        chk("restart_len", plen(0), 1277);
        chk("restart_high", phigh(0), 638);

        // Reset mid-RUN, tone held afterwards
        tone = 32'd988;
        repeat (2700) tick();
        rst = 1'b1;
        tick();
        chk("rst_audio", int'(audio), 0);
        chk("rst_active", int'(tone_active), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_wrap", int'(wrap), 0);
        rst = 1'b0;
        plog.delete(); busy_runs.delete();
        repeat (32 + 1012 * 2 + 20) tick();
        chk("post_rst_busy_len", brun_at(0), 32);
        chk("post_rst_len", plen(0), 1012);
        chk("post_rst_high", phigh(0), 506);

        // Randomized traffic against the model
        repeat (40) begin
            if ($urandom_range(0, 9) == 0)
                tone = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(20000, 40000));
            else
                tone = 32'($urandom_range(2000, 19999));
            vol = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1; tick(); rst = 1'b0;
            end
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40))
                                               : int'($urandom_range(40, 600));
            for (int j = 0; j < hold; j++) begin
                if ($urandom_range(0, 199) == 0) vol = 3'($urandom_range(0, 7));
                tick();
            end
        end
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
